// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between rename and the reservation station: up to 3 enqueues and 3 dequeues per cycle.
// Optional `DISPATCH_QUEUE_HWM_EN adds o_hwm, the peak occupancy seen since reset.
module dispatch_queue #(
    parameter  int BWIDTH = 57,
    parameter  int DEPTH  = 16,
    localparam int PTRW   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic [BWIDTH-1:0] i_enq_bundle0,
    input  logic [BWIDTH-1:0] i_enq_bundle1,
    input  logic [BWIDTH-1:0] i_enq_bundle2,
    input  logic [1:0]        i_enq_count,
    output logic [1:0]        o_enq_room,
    output logic [BWIDTH-1:0] o_bundle0,
    output logic [BWIDTH-1:0] o_bundle1,
    output logic [BWIDTH-1:0] o_bundle2,
    output logic [1:0]        o_insert_count,
    input  logic [1:0]        i_accept_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_err
`ifdef DISPATCH_QUEUE_HWM_EN
    ,
    output logic [PTRW:0]     o_hwm
`endif
);

    logic [BWIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]   rd_ptr, wr_ptr;
    logic [PTRW:0]     occ, occ_nxt, free_cnt;
    logic [1:0]        deq_cnt, enq_cnt;
    logic              viol;
    logic [BWIDTH-1:0] enq_b [3];
    logic [BWIDTH-1:0] rd_b  [3];

    assign enq_b[0] = i_enq_bundle0;
    assign enq_b[1] = i_enq_bundle1;
    assign enq_b[2] = i_enq_bundle2;

    // Room is taken from registered occupancy only, so a same-cycle dequeue never grants extra room.
    assign free_cnt       = (PTRW+1)'(DEPTH) - occ;
    assign o_enq_room     = (free_cnt >= (PTRW+1)'(3)) ? 2'd3 : free_cnt[1:0];
    assign o_insert_count = (occ >= (PTRW+1)'(3)) ? 2'd3 : occ[1:0];
    assign o_empty        = (occ == '0);
    assign o_full         = (occ == (PTRW+1)'(DEPTH));

    assign deq_cnt = (i_accept_count > o_insert_count) ? o_insert_count : i_accept_count;
    assign enq_cnt = (i_enq_count > o_enq_room) ? o_enq_room : i_enq_count;
    assign viol    = (i_accept_count > o_insert_count) || (i_enq_count > o_enq_room);
    assign occ_nxt = i_flush ? '0 : occ + (PTRW+1)'(enq_cnt) - (PTRW+1)'(deq_cnt);

    // NOTE: every variable written in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_b[k] = '0;
            if (2'(k) < o_insert_count)
                rd_b[k] = mem[rd_ptr + PTRW'(k)];
        end
    end

    assign o_bundle0 = rd_b[0];
    assign o_bundle1 = rd_b[1];
    assign o_bundle2 = rd_b[2];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            o_err  <= 1'b0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTRW'(deq_cnt);
            wr_ptr <= wr_ptr + PTRW'(enq_cnt);
            occ    <= occ_nxt;
            if (viol)
                o_err <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; stale entries are harmless because every read is gated by occ.
    always_ff @(posedge i_clk) begin
        if (!i_flush) begin
            for (int k = 0; k < 3; k++) begin
                if (2'(k) < enq_cnt)
                    mem[wr_ptr + PTRW'(k)] <= enq_b[k];
            end
        end
    end

`ifdef DISPATCH_QUEUE_HWM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_hwm <= '0;
        else if (occ_nxt > o_hwm)
            o_hwm <= occ_nxt;
    end
`endif

endmodule
